// File: rtl/stop_watch_btn_cond_if.sv
// Button-conditioner signal bundle: raw push-button inputs and cleaned command pulses.
// The slave side is the conditioner; the master side is whoever drives the buttons.
interface stop_watch_btn_cond_if;
  logic i_btn_sp_raw;
  logic i_btn_st_raw;
  logic o_start_pause;
  logic o_stop;
  logic o_long_press;

  modport slave (
    input  i_btn_sp_raw,
    input  i_btn_st_raw,
    output o_start_pause,
    output o_stop,
    output o_long_press
  );

  modport master (
    output i_btn_sp_raw,
    output i_btn_st_raw,
    input  o_start_pause,
    input  o_stop,
    input  o_long_press
  );
endinterface

// File: rtl/stop_watch_btn_cond.sv
// Stop-watch button conditioner: sync, debounce and press one-shot for start/pause and stop.
// Define LONG_PRESS_EN to build the stop-button hold counter that drives o_long_press.
module stop_watch_btn_cond #(
  parameter int DEBOUNCE_CNT   = 500_000,
  parameter bit BTN_ACTIVE_LOW = 1'b0,
  parameter int LONG_CNT       = 100_000_000
) (
  input logic                   clk,
  input logic                   rst_n,
  stop_watch_btn_cond_if.slave  btn_if
);

  localparam int DBW = $clog2(DEBOUNCE_CNT);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CNT - 1);

  // Index 0 is start/pause, index 1 is stop.
  logic [1:0]          raw;
  logic [1:0]          s1_q, s1_d;
  logic [1:0]          s2_q, s2_d;
  logic [1:0]          stable_q, stable_d;
  logic [1:0][DBW-1:0] cnt_q, cnt_d;
  logic [1:0]          press;
  logic                start_pause_q, start_pause_d;
  logic                stop_q, stop_d;

  assign raw = {btn_if.i_btn_st_raw, btn_if.i_btn_sp_raw};

  always_comb begin
    s1_d     = raw ^ {2{BTN_ACTIVE_LOW}};
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    press    = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          stable_d[i] = s2_q[i];
          press[i]    = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DBW'(1);
        end
      end
    end
    // Stop wins a same-cycle collision; the start/pause press is dropped, not deferred.
    start_pause_d = press[0] & ~press[1];
    stop_d        = press[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q          <= '0;
      s2_q          <= '0;
      stable_q      <= '0;
      cnt_q         <= '0;
      start_pause_q <= 1'b0;
      stop_q        <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      stable_q      <= stable_d;
      cnt_q         <= cnt_d;
      start_pause_q <= start_pause_d;
      stop_q        <= stop_d;
    end
  end

  assign btn_if.o_start_pause = start_pause_q;
  assign btn_if.o_stop        = stop_q;

`ifdef LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CNT + 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CNT - 1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CNT);

  logic [LW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  // Saturating at LONG_CNT keeps the pulse to one per hold.
  always_comb begin
    hold_d = '0;
    long_d = 1'b0;
    if (stable_q[1]) begin
      hold_d = (hold_q == LONG_MAX) ? hold_q : hold_q + LW'(1);
      long_d = (hold_q == LONG_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign btn_if.o_long_press = long_q;
`else
  assign btn_if.o_long_press = 1'b0;
`endif

endmodule
